// File: rtl/rgb_button_conditioner.sv
// rgb_button_conditioner: synchronises and debounces six active-low push buttons
// (R/G/B up/down) and turns each accepted press into a step-pulse train with
// hold-to-repeat. It drives the PWM stage's up inputs (active-high) and down
// inputs (active-low). Holding both buttons of one channel suppresses that channel.
module rgb_button_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 270000,
   parameter int PULSE_LEN       = 1024,
   parameter int REPEAT_DLY      = 8100000,
   parameter int REPEAT_PER      = 1350000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] btn_raw,
   output logic       R_up,
   output logic       G_up,
   output logic       B_up,
   output logic       R_down,
   output logic       G_down,
   output logic       B_down,
   output logic [5:0] pressed
);

   localparam int CW    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int T_A   = (PULSE_LEN > REPEAT_DLY) ? PULSE_LEN : REPEAT_DLY;
   localparam int T_MAX = (T_A > REPEAT_PER) ? T_A : REPEAT_PER;
   localparam int TW    = (T_MAX > 2) ? $clog2(T_MAX) : 1;

   localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_LEN - 1);
   localparam logic [TW-1:0] DLY_LAST   = TW'(REPEAT_DLY - 1);
   localparam logic [TW-1:0] PER_LAST   = TW'(REPEAT_PER - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_WAIT  = 2'd2
   } step_state_t;

   logic [5:0]    sync_r [SYNC_STAGES];
   logic [5:0]    s_s;
   logic [CW-1:0] cnt_r [6];
   logic [5:0]    pressed_r;
   logic [5:0]    go_s;
   step_state_t   state_r [6];
   step_state_t   state_s [6];
   logic [TW-1:0] t_r [6];
   logic [TW-1:0] t_s [6];
   logic [5:0]    first_r;
   logic [5:0]    first_s;
   logic [2:0]    up_r;
   logic [2:0]    down_r;

   // Synchroniser chain; released (high) level on reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_r[k] <= 6'h3F;
      end else begin
         sync_r[0] <= btn_raw;
         for (int k = 1; k < SYNC_STAGES; k++) sync_r[k] <= sync_r[k-1];
      end
   end

   assign s_s = ~sync_r[SYNC_STAGES-1];

   // Debounce: a change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pressed_r <= 6'b000000;
         for (int i = 0; i < 6; i++) cnt_r[i] <= {CW{1'b0}};
      end else begin
         for (int i = 0; i < 6; i++) begin
            if (s_s[i] == pressed_r[i]) begin
               cnt_r[i] <= {CW{1'b0}};
            end else if (cnt_r[i] == DEB_LAST) begin
               pressed_r[i] <= ~pressed_r[i];
               cnt_r[i]     <= {CW{1'b0}};
            end else begin
               cnt_r[i] <= cnt_r[i] + CW'(1);
            end
         end
      end
   end

   // A button may run only while its partner on the same channel is released.
   assign go_s = pressed_r & ~{pressed_r[2:0], pressed_r[5:3]};

   // Step FSM next-state: timer t counts from the start of the current pulse.
   always_comb begin
      for (int i = 0; i < 6; i++) begin
         state_s[i] = state_r[i];
         t_s[i]     = t_r[i];
         first_s[i] = first_r[i];
         case (state_r[i])
            ST_IDLE: begin
               if (go_s[i]) begin
                  state_s[i] = ST_PULSE;
                  t_s[i]     = {TW{1'b0}};
                  first_s[i] = 1'b1;
               end else begin
                  t_s[i] = {TW{1'b0}};
               end
            end
            ST_PULSE: begin
               if (!go_s[i]) begin
                  state_s[i] = ST_IDLE;
                  t_s[i]     = {TW{1'b0}};
               end else if (t_r[i] == PULSE_LAST) begin
                  state_s[i] = ST_WAIT;
                  t_s[i]     = t_r[i] + TW'(1);
               end else begin
                  t_s[i] = t_r[i] + TW'(1);
               end
            end
            ST_WAIT: begin
               if (!go_s[i]) begin
                  state_s[i] = ST_IDLE;
                  t_s[i]     = {TW{1'b0}};
               end else if (first_r[i] && (t_r[i] == DLY_LAST)) begin
                  state_s[i] = ST_PULSE;
                  t_s[i]     = {TW{1'b0}};
                  first_s[i] = 1'b0;
               end else if (!first_r[i] && (t_r[i] == PER_LAST)) begin
                  state_s[i] = ST_PULSE;
                  t_s[i]     = {TW{1'b0}};
               end else begin
                  t_s[i] = t_r[i] + TW'(1);
               end
            end
            default: begin
               state_s[i] = ST_IDLE;
               t_s[i]     = {TW{1'b0}};
               first_s[i] = 1'b0;
            end
         endcase
      end
   end

   // Step FSM state, timer and first-repeat flag registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         first_r <= 6'b000000;
         for (int i = 0; i < 6; i++) begin
            state_r[i] <= ST_IDLE;
            t_r[i]     <= {TW{1'b0}};
         end
      end else begin
         first_r <= first_s;
         for (int i = 0; i < 6; i++) begin
            state_r[i] <= state_s[i];
            t_r[i]     <= t_s[i];
         end
      end
   end

   // Registered outputs decoded from the next state so they line up with the FSM.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         up_r   <= 3'b000;
         down_r <= 3'b111;
      end else begin
         for (int c = 0; c < 3; c++) begin
            up_r[c]   <= (state_s[c] == ST_PULSE);
            down_r[c] <= (state_s[c+3] != ST_PULSE);
         end
      end
   end

   assign R_up    = up_r[0];
   assign G_up    = up_r[1];
   assign B_up    = up_r[2];
   assign R_down  = down_r[0];
   assign G_down  = down_r[1];
   assign B_down  = down_r[2];
   assign pressed = pressed_r;

endmodule
